// File: rtl/la_capture_core.sv
// la_capture_core: segmented logic-analyzer capture engine with pattern/edge
// trigger, runtime pre-trigger depth, per-segment trigger table and BRAM readout.
module la_capture_core #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4096,
    parameter int MAX_SEG_LOG2 = 3,
    parameter int ADDR_BITS    = $clog2(DEPTH),
    parameter int SEG_BITS     = (MAX_SEG_LOG2 < 1) ? 1 : MAX_SEG_LOG2
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic [WIDTH-1:0]     sample_data,
    input  logic                 sample_valid,
    input  logic                 ext_trigger,
    input  logic [1:0]           cfg_trig_mode,
    input  logic [WIDTH-1:0]     cfg_trig_mask,
    input  logic [WIDTH-1:0]     cfg_trig_value,
    input  logic [ADDR_BITS-1:0] cfg_pretrig,
    input  logic [SEG_BITS-1:0]  cfg_seg_log2,
    input  logic                 arm,
    input  logic                 abort,
    output logic [1:0]           state,
    output logic                 done,
    output logic [SEG_BITS:0]    seg_done_count,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    input  logic [SEG_BITS-1:0]  tbl_seg,
    output logic [ADDR_BITS-1:0] tbl_offset
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRETRIG  = 2'd1,
        S_ARMED    = 2'd2,
        S_POSTTRIG = 2'd3
    } state_t;

    state_t               r_state, w_state_nx;
    logic [1:0]           r_mode;
    logic [WIDTH-1:0]     r_mask, r_value;
    logic [ADDR_BITS-1:0] r_p;
    logic [SEG_BITS-1:0]  r_seg_log2;
    logic [SEG_BITS-1:0]  r_seg_idx;
    logic [ADDR_BITS-1:0] r_wptr, r_pre_cnt, r_post_cnt;
    logic                 r_prev_match;
    logic                 r_done;
    logic [SEG_BITS:0]    r_seg_done_count;
    logic [ADDR_BITS-1:0] r_tbl [2**SEG_BITS];
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [WIDTH-1:0]     r_rd_data;
    logic                 r_rd_valid;

    logic [SEG_BITS-1:0]  w_cfg_log2;
    logic [ADDR_BITS-1:0] w_cfg_mask, w_cfg_p;
    logic [ADDR_BITS-1:0] w_seg_mask, w_seg_base, w_wr_addr;
    logic [7:0]           w_base_sh;
    logic [SEG_BITS-1:0]  w_seg_last;
    logic                 w_last_seg, w_match, w_trig_hit, w_pre_last;
    logic                 w_wr_en, w_arm_go, w_trig, w_seg_end, w_run_end;

    // Configuration as seen at arm time: clamped segment count, P limited to seg_len-1.
    assign w_cfg_log2 = (cfg_seg_log2 > SEG_BITS'(MAX_SEG_LOG2)) ? SEG_BITS'(MAX_SEG_LOG2) : cfg_seg_log2;
    assign w_cfg_mask = ADDR_BITS'(DEPTH - 1) >> w_cfg_log2;
    assign w_cfg_p    = (cfg_pretrig > w_cfg_mask) ? w_cfg_mask : cfg_pretrig;

    // Segment geometry for the running capture (seg_len - 1 doubles as the wrap mask).
    assign w_seg_mask = ADDR_BITS'(DEPTH - 1) >> r_seg_log2;
    assign w_base_sh  = 8'(ADDR_BITS) - 8'(r_seg_log2);
    assign w_seg_base = ADDR_BITS'(r_seg_idx) << w_base_sh;
    assign w_wr_addr  = w_seg_base | r_wptr;
    assign w_seg_last = SEG_BITS'((32'd1 << r_seg_log2) - 32'd1);
    assign w_last_seg = (r_seg_idx == w_seg_last);
    assign w_pre_last = ((r_pre_cnt + ADDR_BITS'(1)) == r_p);

    assign w_match = (((sample_data ^ r_value) & r_mask) == '0);

    always_comb begin
        w_trig_hit = 1'b0;
        case (r_mode)
            2'd0:    w_trig_hit = ext_trigger;
            2'd1:    w_trig_hit = w_match;
            2'd2:    w_trig_hit = w_match & ~r_prev_match;
            default: w_trig_hit = ext_trigger | w_match;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) r_state <= S_IDLE;
        else           r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_wr_en    = 1'b0;
        w_arm_go   = 1'b0;
        w_trig     = 1'b0;
        w_seg_end  = 1'b0;
        w_run_end  = 1'b0;
        if (abort) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (arm) begin
                    w_arm_go   = 1'b1;
                    w_state_nx = (w_cfg_p == '0) ? S_ARMED : S_PRETRIG;
                end
                S_PRETRIG: if (sample_valid) begin
                    w_wr_en = 1'b1;
                    if (w_pre_last) w_state_nx = S_ARMED;
                end
                S_ARMED: if (sample_valid) begin
                    w_wr_en = 1'b1;
                    if (w_trig_hit) begin
                        w_trig = 1'b1;
                        if (w_seg_mask == r_p) w_seg_end  = 1'b1;
                        else                   w_state_nx = S_POSTTRIG;
                    end
                end
                S_POSTTRIG: if (sample_valid) begin
                    w_wr_en = 1'b1;
                    if (r_post_cnt == ADDR_BITS'(1)) w_seg_end = 1'b1;
                end
                default: w_state_nx = S_IDLE;
            endcase
            if (w_seg_end) begin
                if (w_last_seg) begin
                    w_run_end  = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = (r_p == '0) ? S_ARMED : S_PRETRIG;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_mode           <= '0;
            r_mask           <= '0;
            r_value          <= '0;
            r_p              <= '0;
            r_seg_log2       <= '0;
            r_seg_idx        <= '0;
            r_wptr           <= '0;
            r_pre_cnt        <= '0;
            r_post_cnt       <= '0;
            r_prev_match     <= 1'b1;
            r_done           <= 1'b0;
            r_seg_done_count <= '0;
            for (int i = 0; i < 2**SEG_BITS; i++) r_tbl[i] <= '0;
        end else begin
            r_done <= w_run_end;
            if (w_arm_go) begin
                r_mode           <= cfg_trig_mode;
                r_mask           <= cfg_trig_mask;
                r_value          <= cfg_trig_value;
                r_p              <= w_cfg_p;
                r_seg_log2       <= w_cfg_log2;
                r_seg_idx        <= '0;
                r_wptr           <= '0;
                r_pre_cnt        <= '0;
                r_seg_done_count <= '0;
                r_prev_match     <= 1'b1;
            end
            if (w_wr_en) begin
                r_wptr <= (r_wptr + ADDR_BITS'(1)) & w_seg_mask;
                if (r_state == S_PRETRIG)  r_pre_cnt  <= r_pre_cnt + ADDR_BITS'(1);
                if (r_state == S_POSTTRIG) r_post_cnt <= r_post_cnt - ADDR_BITS'(1);
                if (r_state == S_PRETRIG || r_state == S_ARMED) r_prev_match <= w_match;
            end
            if (w_trig) begin
                r_tbl[r_seg_idx] <= r_wptr;
                r_post_cnt       <= w_seg_mask - r_p;
            end
            // Segment rollover overrides the per-sample pointer/match updates above.
            if (w_seg_end) begin
                r_seg_done_count <= r_seg_done_count + (SEG_BITS+1)'(1);
                if (!w_last_seg) begin
                    r_seg_idx    <= r_seg_idx + SEG_BITS'(1);
                    r_wptr       <= '0;
                    r_pre_cnt    <= '0;
                    r_prev_match <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (w_wr_en) r_mem[w_wr_addr] <= sample_data;
    end

    // Registered read; a same-address write in this cycle is not yet visible.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= r_mem[rd_addr];
        end
    end

    assign state          = r_state;
    assign done           = r_done;
    assign seg_done_count = r_seg_done_count;
    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign tbl_offset     = r_tbl[tbl_seg];

endmodule

// File: tb/tb_la_capture_core.sv
// Self-checking bench for la_capture_core: directed scenarios plus randomized runs
// checked against a list-based reference model of segmented capture.
module tb_la_capture_core;
    localparam int WIDTH = 8, DEPTH = 16, MAX_SEG_LOG2 = 2, ADDR_BITS = 4, SEG_BITS = 2;

    logic                 pclk = 1'b0, preset_n = 1'b0;
    logic [WIDTH-1:0]     sample_data = '0;
    logic                 sample_valid = 1'b0, ext_trigger = 1'b0;
    logic [1:0]           cfg_trig_mode = '0;
    logic [WIDTH-1:0]     cfg_trig_mask = '0, cfg_trig_value = '0;
    logic [ADDR_BITS-1:0] cfg_pretrig = '0;
    logic [SEG_BITS-1:0]  cfg_seg_log2 = '0;
    logic                 arm = 1'b0, abort = 1'b0;
    logic [1:0]           state;
    logic                 done;
    logic [SEG_BITS:0]    seg_done_count;
    logic                 rd_en = 1'b0;
    logic [ADDR_BITS-1:0] rd_addr = '0;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_valid;
    logic [SEG_BITS-1:0]  tbl_seg = '0;
    logic [ADDR_BITS-1:0] tbl_offset;

    int total = 0, bad = 0;

    int st_data[$];
    bit st_ext[$];
    bit st_vld[$];

    logic [WIDTH-1:0] exp_mem [DEPTH];
    bit               exp_known [DEPTH];
    int               m_off [4];
    int               m_done_segs, m_end_tick;
    int               m_seg_end[$];
    int               obs_state1;

    la_capture_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_SEG_LOG2(MAX_SEG_LOG2)) dut (
        .pclk(pclk), .preset_n(preset_n), .sample_data(sample_data), .sample_valid(sample_valid),
        .ext_trigger(ext_trigger), .cfg_trig_mode(cfg_trig_mode), .cfg_trig_mask(cfg_trig_mask),
        .cfg_trig_value(cfg_trig_value), .cfg_pretrig(cfg_pretrig), .cfg_seg_log2(cfg_seg_log2),
        .arm(arm), .abort(abort), .state(state), .done(done), .seg_done_count(seg_done_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .tbl_seg(tbl_seg), .tbl_offset(tbl_offset)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_stim();
        st_data.delete();
        st_ext.delete();
        st_vld.delete();
    endtask

    // Walk the valid-sample list segment by segment: P pre-trigger samples, search for
    // the first trigger, then seg_len-P-1 post samples; sample c of a segment lands at c mod seg_len.
    task automatic model_run(input int lg_req, input int p_req, input int mode, input int mask,
                             input int value, input int abort_tick);
        int vidx[$];
        int lim, lg, seg_len, p, nseg, pos, vlen, t, e, last, a;
        bit prev, mt, hit;
        lim = (abort_tick >= 0) ? abort_tick : st_vld.size();
        for (int k = 0; k < lim; k++) if (st_vld[k]) vidx.push_back(k);
        vlen = vidx.size();
        lg = (lg_req > 2) ? 2 : lg_req;
        seg_len = DEPTH >> lg;
        p = (p_req > seg_len - 1) ? seg_len - 1 : p_req;
        nseg = 1 << lg;
        m_done_segs = 0;
        m_end_tick = -1;
        m_seg_end.delete();
        pos = 0;
        for (int s = 0; s < nseg; s++) begin
            t = -1;
            prev = 1'b1;
            for (int i = pos; i < vlen; i++) begin
                mt = (((st_data[vidx[i]] ^ value) & mask) == 0);
                case (mode)
                    0:       hit = st_ext[vidx[i]];
                    1:       hit = mt;
                    2:       hit = mt && !prev;
                    default: hit = st_ext[vidx[i]] || mt;
                endcase
                if (i >= pos + p && hit) begin
                    t = i;
                    break;
                end
                prev = mt;
            end
            e = (t < 0) ? vlen - 1 : t + seg_len - p - 1;
            last = (e < vlen) ? e : vlen - 1;
            for (int i = pos; i <= last; i++) begin
                a = s * seg_len + (i - pos) % seg_len;
                exp_mem[a] = WIDTH'(st_data[vidx[i]]);
                exp_known[a] = 1'b1;
            end
            if (t < 0 || e >= vlen) break;
            m_off[s] = (t - pos) % seg_len;
            m_done_segs++;
            m_seg_end.push_back(vidx[e]);
            if (s == nseg - 1) m_end_tick = vidx[e];
            pos = e + 1;
        end
    endtask

    task automatic readback_all(input string name);
        int a_last;
        a_last = -1;
        for (int a = 0; a < DEPTH; a++) begin
            if (!exp_known[a]) continue;
            rd_en = 1'b1;
            rd_addr = ADDR_BITS'(a);
            tick();
            a_last = a;
            total++;
            if (rd_valid !== 1'b1 || rd_data !== exp_mem[a]) begin
                bad++;
                $display("FAIL %s read addr=%0d got valid=%0b data=%0h exp valid=1 data=%0h",
                         name, a, rd_valid, rd_data, exp_mem[a]);
            end
        end
        rd_en = 1'b0;
        tick();
        if (a_last >= 0) begin
            total++;
            if (rd_valid !== 1'b0 || rd_data !== exp_mem[a_last]) begin
                bad++;
                $display("FAIL %s read_idle got valid=%0b data=%0h exp valid=0 data=%0h",
                         name, rd_valid, rd_data, exp_mem[a_last]);
            end
        end
    endtask

    task automatic run_capture(input int lg_req, input int p_req, input int mode, input int mask,
                               input int value, input int abort_tick, input string name);
        int lim, sdc, lg, p_eff, exp_st;
        model_run(lg_req, p_req, mode, mask, value, abort_tick);
        lim = st_vld.size();
        if (abort_tick < 0 && m_end_tick < 0) abort_tick = lim;
        lg = (lg_req > 2) ? 2 : lg_req;
        p_eff = (p_req > (DEPTH >> lg) - 1) ? (DEPTH >> lg) - 1 : p_req;
        exp_st = (p_eff == 0) ? 2 : 1;

        cfg_seg_log2 = SEG_BITS'(lg_req);
        cfg_pretrig = ADDR_BITS'(p_req);
        cfg_trig_mode = 2'(mode);
        cfg_trig_mask = WIDTH'(mask);
        cfg_trig_value = WIDTH'(value);
        arm = 1'b1;
        sample_valid = 1'b1;
        sample_data = WIDTH'($urandom);
        ext_trigger = 1'b1;
        tick();
        arm = 1'b0;
        total++;
        if (state !== 2'(exp_st) || seg_done_count !== '0) begin
            bad++;
            $display("FAIL %s arm got state=%0d sdc=%0d exp state=%0d sdc=0", name, state, seg_done_count, exp_st);
        end
        // Scramble configuration mid-run; the capture must keep its latched copy.
        cfg_seg_log2 = SEG_BITS'($urandom);
        cfg_pretrig = ADDR_BITS'($urandom);
        cfg_trig_mode = 2'($urandom);
        cfg_trig_mask = WIDTH'($urandom);
        cfg_trig_value = WIDTH'($urandom);
        obs_state1 = -1;

        for (int t = 0; t <= lim; t++) begin
            if (t == abort_tick) begin
                abort = 1'b1;
                sample_valid = 1'b1;
                ext_trigger = 1'b1;
                sample_data = WIDTH'($urandom);
                tick();
                abort = 1'b0;
                sample_valid = 1'b0;
                ext_trigger = 1'b0;
                total++;
                if (state !== 2'd0 || done !== 1'b0 || seg_done_count !== 3'(m_done_segs)) begin
                    bad++;
                    $display("FAIL %s abort got state=%0d done=%0b sdc=%0d exp state=0 done=0 sdc=%0d",
                             name, state, done, seg_done_count, m_done_segs);
                end
                break;
            end
            sample_data = WIDTH'(st_data[t]);
            ext_trigger = st_ext[t];
            sample_valid = st_vld[t];
            arm = ($urandom_range(0, 7) == 0);
            tick();
            arm = 1'b0;
            if (t == 0) obs_state1 = int'(state);
            sdc = 0;
            foreach (m_seg_end[k]) if (m_seg_end[k] <= t) sdc++;
            total++;
            if (done !== (t == m_end_tick) || seg_done_count !== 3'(sdc)) begin
                bad++;
                $display("FAIL %s tick=%0d got done=%0b sdc=%0d exp done=%0b sdc=%0d",
                         name, t, done, seg_done_count, (t == m_end_tick), sdc);
            end
            if (t == m_end_tick) begin
                total++;
                if (state !== 2'd0) begin
                    bad++;
                    $display("FAIL %s end_state got=%0d exp=0", name, state);
                end
                break;
            end
        end
        sample_valid = 1'b0;
        ext_trigger = 1'b0;

        for (int s = 0; s < m_done_segs; s++) begin
            tbl_seg = SEG_BITS'(s);
            #1;
            total++;
            if (tbl_offset !== ADDR_BITS'(m_off[s])) begin
                bad++;
                $display("FAIL %s table seg=%0d got=%0d exp=%0d", name, s, tbl_offset, m_off[s]);
            end
        end
        readback_all(name);
    endtask

    task automatic check_tbl(input int seg, input int exp, input string name);
        tbl_seg = SEG_BITS'(seg);
        #1;
        total++;
        if (tbl_offset !== ADDR_BITS'(exp)) begin
            bad++;
            $display("FAIL %s table seg=%0d got=%0d exp=%0d", name, seg, tbl_offset, exp);
        end
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (state !== 2'd0 || done !== 1'b0 || seg_done_count !== '0 || rd_valid !== 1'b0 || rd_data !== '0) begin
            bad++;
            $display("FAIL reset outputs got state=%0d done=%0b sdc=%0d rv=%0b rd=%0h exp all 0",
                     state, done, seg_done_count, rd_valid, rd_data);
        end
        for (int s = 0; s < 4; s++) check_tbl(s, 0, "reset");
        preset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clear_stim();
        for (int i = 0; i < 30; i++) begin
            st_data.push_back(i);
            st_ext.push_back(i == 20);
            st_vld.push_back(1'b1);
        end
        run_capture(0, 8, 0, 0, 0, -1, "basic");
        check_tbl(0, 4, "basic_const");
        total++;
        if (seg_done_count !== 3'd1) begin
            bad++;
            $display("FAIL basic_sdc got=%0d exp=1", seg_done_count);
        end
        for (int k = 0; k < 16; k++) begin
            rd_en = 1'b1;
            rd_addr = ADDR_BITS'((4 + 8 + k) % 16);
            tick();
            total++;
            if (rd_data !== WIDTH'(12 + k)) begin
                bad++;
                $display("FAIL basic_order k=%0d got=%0d exp=%0d", k, rd_data, 12 + k);
            end
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_rising();
        clear_stim();
        for (int i = 0; i < 30; i++) begin
            st_data.push_back((i == 6 || i == 7) ? i * 2 : i * 2 + 1);
            st_ext.push_back(1'b0);
            st_vld.push_back(1'b1);
        end
        run_capture(0, 2, 2, 1, 1, -1, "rising");
        check_tbl(0, 8, "rising_const");
    endtask

    task automatic test_segmented();
        clear_stim();
        for (int i = 0; i < 50; i++) begin
            st_data.push_back($urandom_range(0, 255));
            st_ext.push_back(i % 10 == 0);
            st_vld.push_back(1'b1);
        end
        run_capture(2, 1, 0, 0, 0, -1, "segmented");
        check_tbl(0, 2, "segmented_const");
        for (int s = 1; s < 4; s++) check_tbl(s, 3, "segmented_const");
    endtask

    task automatic test_p0();
        clear_stim();
        for (int i = 0; i < 20; i++) begin
            st_data.push_back($urandom_range(0, 255));
            st_ext.push_back(i == 0 || i == 8);
            st_vld.push_back(1'b1);
        end
        run_capture(1, 0, 0, 0, 0, -1, "p0");
        total++;
        if (obs_state1 != 3) begin
            bad++;
            $display("FAIL p0_state_after_trigger got=%0d exp=3", obs_state1);
        end
        check_tbl(0, 0, "p0_const");
        check_tbl(1, 0, "p0_const");
    endtask

    task automatic test_readout();
        logic [WIDTH-1:0] old [DEPTH];
        for (int a = 0; a < DEPTH; a++) old[a] = exp_mem[a];
        cfg_seg_log2 = 2'd0;
        cfg_pretrig = 4'd4;
        cfg_trig_mode = 2'd0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sample_data = WIDTH'(100 + i);
            sample_valid = 1'b1;
            ext_trigger = 1'b0;
            rd_en = 1'b1;
            rd_addr = ADDR_BITS'(i);
            tick();
            total++;
            if (rd_valid !== 1'b1 || rd_data !== old[i]) begin
                bad++;
                $display("FAIL readout_rw addr=%0d got valid=%0b data=%0h exp valid=1 data=%0h",
                         i, rd_valid, rd_data, old[i]);
            end
            exp_mem[i] = WIDTH'(100 + i);
            exp_known[i] = 1'b1;
        end
        rd_en = 1'b0;
        sample_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (state !== 2'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL readout_abort got state=%0d done=%0b exp state=0 done=0", state, done);
        end
        readback_all("readout_new");
    endtask

    task automatic test_abort();
        clear_stim();
        for (int i = 0; i < 50; i++) begin
            st_data.push_back($urandom_range(0, 255));
            st_ext.push_back(i % 10 == 0);
            st_vld.push_back(1'b1);
        end
        run_capture(2, 1, 0, 0, 0, 31, "abort");
        total++;
        if (seg_done_count !== 3'd2 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_const got sdc=%0d done=%0b exp sdc=2 done=0", seg_done_count, done);
        end
        clear_stim();
        for (int i = 0; i < 30; i++) begin
            st_data.push_back($urandom_range(0, 255));
            st_ext.push_back(i == 9);
            st_vld.push_back(1'b1);
        end
        run_capture(0, 3, 0, 0, 0, -1, "abort_restart");
        check_tbl(0, 9, "abort_restart_const");
    endtask

    task automatic test_random();
        int mask, value;
        for (int r = 0; r < 8; r++) begin
            clear_stim();
            mask = $urandom_range(1, 3);
            value = $urandom_range(0, 3) & mask;
            for (int i = 0; i < 160; i++) begin
                st_data.push_back($urandom_range(0, 255));
                st_ext.push_back($urandom_range(0, 11) == 0);
                st_vld.push_back($urandom_range(0, 4) != 0);
            end
            run_capture($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3),
                        mask, value, -1, "random");
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) exp_known[a] = 1'b0;
        test_reset();
        test_basic();
        test_rising();
        test_segmented();
        test_p0();
        test_readout();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
